// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the RV32 hazard unit.
//   REG_AW     : default register-number width (32 architectural registers).
//   fwd_sel_e  : EX operand source select driven by the forwarding logic.
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hz_scoreboard.sv
// ----------------------------------------------------------------------------
// hz_scoreboard
//   Per-register pending bits for long-latency writers (variable-latency loads,
//   MUL/DIV) plus the count of outstanding writes.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rs1n_id, rs2n_id    ID source registers (RAW check)
//   rdn_ex              EX destination (WAW check / entry to set)
//   issue_long_ex       EX dispatches to a long-latency unit this cycle
//   redirect_ex         EX mispredict; the EX instruction is squashed
//   long_done(_rd)      long-latency result written back this cycle
//   sb_raw              an ID source is still pending
//   sb_waw              EX issue targets a register that is still pending
//   sb_full             EX issue while MAX_PEND writes are already outstanding
//   pend_cnt            number of outstanding long-latency writes
// ----------------------------------------------------------------------------
module hz_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int MAX_PEND = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REG_AW-1:0]               rs1n_id,
    input  logic [REG_AW-1:0]               rs2n_id,
    input  logic [REG_AW-1:0]               rdn_ex,
    input  logic                            issue_long_ex,
    input  logic                            redirect_ex,
    input  logic                            long_done,
    input  logic [REG_AW-1:0]               long_done_rd,
    output logic                            sb_raw,
    output logic                            sb_waw,
    output logic                            sb_full,
    output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt
);

    localparam int NREG = 2 ** REG_AW;
    localparam int PW   = $clog2(MAX_PEND + 1);

    logic [NREG-1:0] sb;
    logic            set_en;
    logic            clr_en;

    // x0 is never set, but the explicit masks keep the checks independent of that.
    assign sb_raw  = ((rs1n_id != '0) && sb[rs1n_id]) || ((rs2n_id != '0) && sb[rs2n_id]);
    assign sb_waw  = issue_long_ex && (rdn_ex != '0) && sb[rdn_ex];
    assign sb_full = issue_long_ex && (pend_cnt == PW'(MAX_PEND));

    assign set_en = issue_long_ex && (rdn_ex != '0) && !sb_waw && !sb_full && !redirect_ex;
    // A completion for a register that is not pending is ignored so the count
    // can never underflow.
    assign clr_en = long_done && (long_done_rd != '0) && sb[long_done_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb       <= '0;
            pend_cnt <= '0;
        end else begin
            // Set and clear of the same entry cannot coincide: that case is a WAW stall.
            if (clr_en) sb[long_done_rd] <= 1'b0;
            if (set_en) sb[rdn_ex]       <= 1'b1;
            if (set_en && !clr_en)      pend_cnt <= pend_cnt + PW'(1);
            else if (clr_en && !set_en) pend_cnt <= pend_cnt - PW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage RV32 pipeline: EX operand forwarding from
//   MEM/WB, load-use and long-latency scoreboard stalls, branch-redirect
//   flushes, and saturating performance counters.
// Ports
//   rs1n_ex, rs2n_ex            EX sources       -> fwd_src1_ex, fwd_src2_ex
//   rdn_mem/wb, regwrite_mem/wb MEM / WB writers (forwarding candidates)
//   rs1n_id, rs2n_id, rdn_ex,
//   memtoreg_ex, issue_long_ex  hazard detection inputs
//   long_done, long_done_rd     long-latency writeback
//   redirect_ex                 mispredict resolved in EX (wins over stalls)
//   stall_if, stall_id          hold PC and IF/ID
//   flush_id, flush_ex          bubble IF/ID resp. ID/EX
//   pend_cnt                    outstanding long-latency writes
//   stall_cycles, flush_events  saturating performance counters
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REG_AW-1:0]               rs1n_ex,
    input  logic [REG_AW-1:0]               rs2n_ex,
    input  logic [REG_AW-1:0]               rdn_mem,
    input  logic [REG_AW-1:0]               rdn_wb,
    input  logic                            regwrite_mem,
    input  logic                            regwrite_wb,
    input  logic [REG_AW-1:0]               rs1n_id,
    input  logic [REG_AW-1:0]               rs2n_id,
    input  logic [REG_AW-1:0]               rdn_ex,
    input  logic                            memtoreg_ex,
    input  logic                            issue_long_ex,
    input  logic                            long_done,
    input  logic [REG_AW-1:0]               long_done_rd,
    input  logic                            redirect_ex,
    output logic [1:0]                      fwd_src1_ex,
    output logic [1:0]                      fwd_src2_ex,
    output logic                            stall_if,
    output logic                            stall_id,
    output logic                            flush_id,
    output logic                            flush_ex,
    output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
    output logic [CNT_W-1:0]                stall_cycles,
    output logic [CNT_W-1:0]                flush_events
);

    import hazard_pkg::*;

    logic sb_raw;
    logic sb_waw;
    logic sb_full;
    logic load_use;
    logic stall;

    // MEM holds the younger result, so it wins over WB.
    function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] rd_mem,
                                          input logic              wr_mem,
                                          input logic [REG_AW-1:0] rd_wb,
                                          input logic              wr_wb);
        if (src == '0)                  return FWD_RF;
        else if (wr_mem && src == rd_mem) return FWD_MEM;
        else if (wr_wb && src == rd_wb)   return FWD_WB;
        else                            return FWD_RF;
    endfunction

    always_comb begin
        fwd_src1_ex = fwd_pick(rs1n_ex, rdn_mem, regwrite_mem, rdn_wb, regwrite_wb);
        fwd_src2_ex = fwd_pick(rs2n_ex, rdn_mem, regwrite_mem, rdn_wb, regwrite_wb);
    end

    hz_scoreboard #(
        .REG_AW   (REG_AW),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1n_id       (rs1n_id),
        .rs2n_id       (rs2n_id),
        .rdn_ex        (rdn_ex),
        .issue_long_ex (issue_long_ex),
        .redirect_ex   (redirect_ex),
        .long_done     (long_done),
        .long_done_rd  (long_done_rd),
        .sb_raw        (sb_raw),
        .sb_waw        (sb_waw),
        .sb_full       (sb_full),
        .pend_cnt      (pend_cnt)
    );

    assign load_use = memtoreg_ex && (rdn_ex != '0) &&
                      ((rs1n_id == rdn_ex) || (rs2n_id == rdn_ex));
    assign stall    = load_use || sb_raw || sb_waw || sb_full;

    // A redirect squashes both younger stages, so any pending stall is moot.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (redirect_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else begin
            stall_if = stall;
            stall_id = stall;
            flush_ex = stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_id && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_ex && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = 32;
    localparam int PW       = $clog2(MAX_PEND + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [REG_AW-1:0] rs1n_ex, rs2n_ex, rdn_mem, rdn_wb;
    logic              regwrite_mem, regwrite_wb;
    logic [REG_AW-1:0] rs1n_id, rs2n_id, rdn_ex;
    logic              memtoreg_ex, issue_long_ex, long_done, redirect_ex;
    logic [REG_AW-1:0] long_done_rd;
    logic [1:0]        fwd_src1_ex, fwd_src2_ex;
    logic              stall_if, stall_id, flush_id, flush_ex;
    logic [PW-1:0]     pend_cnt;
    logic [CNT_W-1:0]  stall_cycles, flush_events;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1n_ex       (rs1n_ex),
        .rs2n_ex       (rs2n_ex),
        .rdn_mem       (rdn_mem),
        .rdn_wb        (rdn_wb),
        .regwrite_mem  (regwrite_mem),
        .regwrite_wb   (regwrite_wb),
        .rs1n_id       (rs1n_id),
        .rs2n_id       (rs2n_id),
        .rdn_ex        (rdn_ex),
        .memtoreg_ex   (memtoreg_ex),
        .issue_long_ex (issue_long_ex),
        .long_done     (long_done),
        .long_done_rd  (long_done_rd),
        .redirect_ex   (redirect_ex),
        .fwd_src1_ex   (fwd_src1_ex),
        .fwd_src2_ex   (fwd_src2_ex),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .pend_cnt      (pend_cnt),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending long-latency writes kept as a list of register numbers.
    int     pend_q[$];
    longint m_stalls;
    longint m_flushes;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    function automatic bit is_pend(input int r);
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(input int src);
        if (src == 0) return 2'b00;
        if (regwrite_mem && src == int'(rdn_mem)) return 2'b10;
        if (regwrite_wb && src == int'(rdn_wb)) return 2'b01;
        return 2'b00;
    endfunction

    // Hazard condition before redirect priority is applied.
    function automatic bit m_hazard();
        bit lu, raw, waw, full;
        lu   = memtoreg_ex && rdn_ex != 0 && (rs1n_id == rdn_ex || rs2n_id == rdn_ex);
        raw  = (rs1n_id != 0 && is_pend(int'(rs1n_id))) || (rs2n_id != 0 && is_pend(int'(rs2n_id)));
        waw  = issue_long_ex && rdn_ex != 0 && is_pend(int'(rdn_ex));
        full = issue_long_ex && pend_q.size() == MAX_PEND;
        return lu || raw || waw || full;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q.delete();
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            bit do_set;
            do_set = issue_long_ex && rdn_ex != 0 && !is_pend(int'(rdn_ex)) &&
                     pend_q.size() < MAX_PEND && !redirect_ex;
            if (!redirect_ex && m_hazard() && m_stalls < CNT_MAX) m_stalls++;
            if (redirect_ex && m_flushes < CNT_MAX) m_flushes++;
            if (long_done && long_done_rd != 0) begin
                for (int i = 0; i < pend_q.size(); i++)
                    if (pend_q[i] == int'(long_done_rd)) begin
                        pend_q.delete(i);
                        break;
                    end
            end
            if (do_set) pend_q.push_back(int'(rdn_ex));
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit h;
        h = m_hazard();
        chk("fwd_src1_ex", 64'(fwd_src1_ex), 64'(m_fwd(int'(rs1n_ex))));
        chk("fwd_src2_ex", 64'(fwd_src2_ex), 64'(m_fwd(int'(rs2n_ex))));
        chk("stall_if", 64'(stall_if), 64'(!redirect_ex && h));
        chk("stall_id", 64'(stall_id), 64'(!redirect_ex && h));
        chk("flush_id", 64'(flush_id), 64'(redirect_ex));
        chk("flush_ex", 64'(flush_ex), 64'(redirect_ex || h));
        chk("pend_cnt", 64'(pend_cnt), 64'(pend_q.size()));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
        chk("flush_events", 64'(flush_events), 64'(m_flushes));
    end

    // ---------------- driver tasks ----------------
    task automatic clr_in();
        rs1n_ex = '0; rs2n_ex = '0; rdn_mem = '0; rdn_wb = '0;
        regwrite_mem = 1'b0; regwrite_wb = 1'b0;
        rs1n_id = '0; rs2n_id = '0; rdn_ex = '0;
        memtoreg_ex = 1'b0; issue_long_ex = 1'b0;
        long_done = 1'b0; long_done_rd = '0; redirect_ex = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clr_in();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        mid();
        chk("rst_pend", 64'(pend_cnt), 64'd0);
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("rst_flush_events", 64'(flush_events), 64'd0);
        #2 rst_n = 1'b1;

        // Forwarding priority
        tick();
        rs1n_ex = 5'd5; rs2n_ex = 5'd6; rdn_mem = 5'd5; rdn_wb = 5'd5;
        regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        mid(); chk("fwd_mem", 64'(fwd_src1_ex), 64'h2);
        tick(); rdn_mem = 5'd6;
        mid(); chk("fwd_wb", 64'(fwd_src1_ex), 64'h1);
        chk("fwd2_mem", 64'(fwd_src2_ex), 64'h2);
        tick(); rs1n_ex = 5'd0;
        mid(); chk("fwd_x0", 64'(fwd_src1_ex), 64'h0);

        // Load-use
        tick(); clr_in();
        memtoreg_ex = 1'b1; rdn_ex = 5'd7; rs2n_id = 5'd7;
        mid();
        chk("lu_stall_id", 64'(stall_id), 64'd1);
        chk("lu_stall_if", 64'(stall_if), 64'd1);
        chk("lu_flush_ex", 64'(flush_ex), 64'd1);
        chk("lu_flush_id", 64'(flush_id), 64'd0);
        tick(); rdn_ex = 5'd0; rs2n_id = 5'd0;
        mid(); chk("lu_x0", 64'(stall_id), 64'd0);

        // Long-latency RAW
        tick(); clr_in();
        issue_long_ex = 1'b1; rdn_ex = 5'd9;
        mid(); chk("issue9_stall", 64'(stall_id), 64'd0);
        tick(); clr_in(); rs1n_id = 5'd9;
        mid(); chk("raw9_pend", 64'(pend_cnt), 64'd1);
        chk("raw9_stall_a", 64'(stall_id), 64'd1);
        tick();
        mid(); chk("raw9_stall_b", 64'(stall_id), 64'd1);
        tick(); long_done = 1'b1; long_done_rd = 5'd9;
        mid(); chk("raw9_done_stall", 64'(stall_id), 64'd1);
        tick(); long_done = 1'b0; long_done_rd = '0;
        mid(); chk("raw9_release", 64'(stall_id), 64'd0);
        chk("raw9_pend0", 64'(pend_cnt), 64'd0);
        chk("stall_cycles_4", 64'(stall_cycles), 64'd4);

        // Fill to MAX_PEND
        for (int r = 1; r <= 4; r++) begin
            tick(); clr_in();
            issue_long_ex = 1'b1; rdn_ex = REG_AW'(r);
        end
        tick(); rdn_ex = 5'd5;
        mid(); chk("full_pend", 64'(pend_cnt), 64'd4);
        chk("full_stall", 64'(stall_id), 64'd1);
        tick(); long_done = 1'b1; long_done_rd = 5'd1;
        mid(); chk("full_done_stall", 64'(stall_id), 64'd1);
        tick(); long_done = 1'b0; long_done_rd = '0;
        mid(); chk("freed_stall", 64'(stall_id), 64'd0);
        chk("freed_pend", 64'(pend_cnt), 64'd3);
        tick(); clr_in();
        mid(); chk("refill_pend", 64'(pend_cnt), 64'd4);
        chk("stall_cycles_6", 64'(stall_cycles), 64'd6);

        // Redirect beats a scoreboard RAW stall and squashes the issue
        tick(); long_done = 1'b1; long_done_rd = 5'd5;
        mid();
        tick(); clr_in();
        redirect_ex = 1'b1; rs1n_id = 5'd2; issue_long_ex = 1'b1; rdn_ex = 5'd10;
        mid();
        chk("redir_flush_id", 64'(flush_id), 64'd1);
        chk("redir_flush_ex", 64'(flush_ex), 64'd1);
        chk("redir_stall_id", 64'(stall_id), 64'd0);
        chk("redir_stall_if", 64'(stall_if), 64'd0);
        chk("redir_pend", 64'(pend_cnt), 64'd3);
        tick(); clr_in(); rs1n_id = 5'd10;
        mid();
        chk("redir_noset_pend", 64'(pend_cnt), 64'd3);
        chk("redir_noset_stall", 64'(stall_id), 64'd0);
        chk("flush_events_1", 64'(flush_events), 64'd1);
        chk("stall_cycles_kept", 64'(stall_cycles), 64'd6);

        // Asynchronous reset mid-stall
        tick(); rs1n_id = 5'd3;
        mid(); chk("pre_rst_stall", 64'(stall_id), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pend", 64'(pend_cnt), 64'd0);
        chk("arst_stall", 64'(stall_id), 64'd0);
        chk("arst_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("arst_flush_events", 64'(flush_events), 64'd0);
        mid();
        #2 rst_n = 1'b1;
        tick();
        mid(); chk("post_rst_stall", 64'(stall_id), 64'd0);
        chk("post_rst_pend", 64'(pend_cnt), 64'd0);

        tick(); clr_in();
        mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
